alu_input_conditioner: RTL and testbench
========================================

ALU_INPUT_CONDITIONER -- requirements
Module: alu_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, which is the number of consecutive stable cycles required to accept a btnC level change; legal range is 2 or more.
REQ-002 SHALL have port clk  input  1  single system clock; all flops are on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port sw  input  8  raw operand A switches (asynchronous).
REQ-005 SHALL have port sw2  input  5  raw operand B switches (asynchronous).
REQ-006 SHALL have port sel  input  3  raw ALU operation select (asynchronous).
REQ-007 SHALL have port btnC  input  1  raw, bouncing push-button (asynchronous).
REQ-008 SHALL have port a_q  output  8  captured operand A.
REQ-009 SHALL have port b_q  output  5  captured operand B; the downstream block zero-extends it to 8 bits.
REQ-010 SHALL have port sel_q  output  3  captured operation select.
REQ-011 SHALL have port btn_db  output  1  debounced btnC level; used as Cin.
REQ-012 SHALL have port op_valid  output  1  one-cycle pulse marking a new capture.
REQ-013 SHALL have port cap_cnt  output  8  number of captures, modulo 256.

Function
REQ-014 SHALL pass sw, sw2, sel and btnC each through a two-flop synchronizer; all internal logic uses only the second-stage values (s_sw, s_sw2, s_sel, s_btn).
REQ-015 SHALL implement an FSM with states IDLE, PRESS_CHK, HELD and REL_CHK, plus a debounce counter of width $clog2(DEBOUNCE_CYCLES).
REQ-016 SHALL, in IDLE, go to PRESS_CHK when s_btn=1 and clear the counter; otherwise it stays in IDLE.
REQ-017 SHALL, in PRESS_CHK:
- if s_btn=0, go to IDLE with the counter cleared;
- else if counter = DEBOUNCE_CYCLES-1, go to HELD;
- else increment the counter.
REQ-018 SHALL, in HELD, go to REL_CHK when s_btn=0 and clear the counter.
REQ-019 SHALL, in REL_CHK:
- if s_btn=1, return to HELD;
- else if counter = DEBOUNCE_CYCLES-1, go to IDLE;
- else increment the counter.
REQ-020 SHALL register btn_db as 1 in HELD and REL_CHK and 0 in IDLE and PRESS_CHK.
REQ-021 SHALL, on the clock edge that performs the PRESS_CHK->HELD transition, load a_q<=s_sw, b_q<=s_sw2, sel_q<=s_sel, set op_valid<=1 and increment cap_cnt (255 wraps to 0).
REQ-022 SHALL hold op_valid at 0 on every other edge, so the pulse is exactly one cycle wide; a held button produces exactly one pulse.
REQ-023 SHALL hold a_q, b_q and sel_q constant between captures, whatever the switches do.
REQ-024 SHALL meet this latency: if edge 0 is the first edge sampling btnC=1 and btnC stays stable, the PRESS_CHK->HELD transition occurs at edge 2+DEBOUNCE_CYCLES.
REQ-025 SHALL meet this release latency: with btnC=0 stable, btn_db falls 2+DEBOUNCE_CYCLES edges after the first edge sampling 0.
REQ-026 SHALL restart the full debounce window on any glitch shorter than DEBOUNCE_CYCLES in either check state; a glitch SHALL produce no op_valid and no btn_db change.
REQ-027 SHALL be purely registered on every output, with no combinational path from input to output.

Reset
REQ-028 SHALL, while rst=1, immediately force:
- FSM to IDLE;
- counter, synchronizers, a_q, b_q, sel_q, btn_db, op_valid and cap_cnt to 0.
REQ-029 SHALL abandon any debounce in progress when reset occurs mid-debounce, with no op_valid.
REQ-030 SHALL, after rst falls with btnC held high, require a full 2+DEBOUNCE_CYCLES edges before capture.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 SHALL cover a clean press: sw=0xA5, sw2=0x13, sel=3'b010 stable, btnC 0->1 held -> one op_valid pulse at edge 6; a_q=0xA5, b_q=0x13, sel_q=2, cap_cnt=1, btn_db=1.
REQ-032 SHALL cover bounce: btnC toggles 1,0,1,0 every 2 cycles, then stays 1 -> no pulse during the bounce; exactly one pulse 6 edges after the final rise.
REQ-033 SHALL cover hold and release: button held 50 cycles, then released -> exactly one pulse; btn_db falls 6 edges after release; operands change after capture -> a_q, b_q and sel_q unchanged.
REQ-034 SHALL cover reset mid-debounce: rst asserted at edge 4 of a press -> outputs 0 asynchronously and no pulse; rst released with btnC=1 -> pulse 6 edges after the first sampling edge.
REQ-035 SHALL cover wrap-around: 256 clean presses -> cap_cnt returns to 0 and 256 pulses are counted.
REQ-036 SHALL cover a release glitch: in HELD, btnC drops for 2 cycles -> btn_db stays 1 and no extra pulse occurs.

Source files
------------

// File: rtl/alu_input_conditioner.sv
// rtl/alu_input_conditioner.sv - synchronizes ALU switch inputs and captures them on a debounced button press
module alu_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic [4:0] sw2,
    input  logic [2:0] sel,
    input  logic       btnC,
    output logic [7:0] a_q,
    output logic [4:0] b_q,
    output logic [2:0] sel_q,
    output logic       btn_db,
    output logic       op_valid,
    output logic [7:0] cap_cnt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    logic [7:0]    sw_meta_q, s_sw;
    logic [4:0]    sw2_meta_q, s_sw2;
    logic [2:0]    sel_meta_q, s_sel;
    logic          btn_meta_q, s_btn;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          capture_d;
    logic          btn_db_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q  <= '0;
            s_sw       <= '0;
            sw2_meta_q <= '0;
            s_sw2      <= '0;
            sel_meta_q <= '0;
            s_sel      <= '0;
            btn_meta_q <= 1'b0;
            s_btn      <= 1'b0;
        end else begin
            sw_meta_q  <= sw;
            s_sw       <= sw_meta_q;
            sw2_meta_q <= sw2;
            s_sw2      <= sw2_meta_q;
            sel_meta_q <= sel;
            s_sel      <= sel_meta_q;
            btn_meta_q <= btnC;
            s_btn      <= btn_meta_q;
        end
    end

    // Any disagreement with the level being checked abandons the window, so glitches restart it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_btn) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!s_btn) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = HELD;
                    capture_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!s_btn) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
            end
            REL_CHK: begin
                if (s_btn) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        btn_db_d = (state_d == HELD) || (state_d == REL_CHK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            btn_db   <= 1'b0;
            op_valid <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            cap_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            btn_db   <= btn_db_d;
            op_valid <= capture_d;
            if (capture_d) begin
                a_q     <= s_sw;
                b_q     <= s_sw2;
                sel_q   <= s_sel;
                cap_cnt <= cap_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_input_conditioner.sv
// tb/tb_alu_input_conditioner.sv - scoreboard bench for alu_input_conditioner with DEBOUNCE_CYCLES=4
module tb_alu_input_conditioner;

    localparam int DB  = 4;
    localparam int LAT = DB + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw = '0;
    logic [4:0] sw2 = '0;
    logic [2:0] sel = '0;
    logic       btnC = 1'b0;
    logic [7:0] a_q;
    logic [4:0] b_q;
    logic [2:0] sel_q;
    logic       btn_db;
    logic       op_valid;
    logic [7:0] cap_cnt;

    alu_input_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .sw(sw), .sw2(sw2), .sel(sel), .btnC(btnC),
        .a_q(a_q), .b_q(b_q), .sel_q(sel_q), .btn_db(btn_db),
        .op_valid(op_valid), .cap_cnt(cap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [4:0] b;
        logic [2:0] s;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_pulses = 0;
    logic [7:0] exp_cnt = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && op_valid) begin
            n_pulses++;
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("capture", {a_q, 3'b0, b_q, 5'b0, sel_q, cap_cnt, 7'b0, btn_db},
                      {e.a, 3'b0, e.b, 5'b0, e.s, e.cnt, 7'b0, 1'b1});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [7:0] a, input logic [4:0] b, input logic [2:0] s);
        tick();
        sw = a; sw2 = b; sel = s;
        repeat (3) tick();
    endtask

    task automatic expect_pulse(input int at_cyc);
        exp_t e;
        exp_cnt = exp_cnt + 8'd1;
        e.a = sw; e.b = sw2; e.s = sel; e.cnt = exp_cnt; e.cyc = at_cyc;
        sb.push_back(e);
    endtask

    task automatic release_and_check();
        int r;
        int fell;
        btnC = 1'b0;
        r = cyc;
        fell = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!btn_db) begin
                fell = cyc;
                break;
            end
        end
        check("release_latency", fell, r + LAT);
        #1;
    endtask

    task automatic press(input logic [7:0] a, input logic [4:0] b, input logic [2:0] s, input int hold);
        set_ops(a, b, s);
        btnC = 1'b1;
        expect_pulse(cyc + LAT);
        repeat (hold) tick();
        release_and_check();
    endtask

    initial begin
        int n0;
        #1;
        check("reset_outputs", {a_q, 3'b0, b_q, 5'b0, sel_q, btn_db, op_valid, cap_cnt}, 32'd0);
        repeat (3) tick();
        rst = 1'b0;

        // clean press
        press(8'hA5, 5'h13, 3'b010, 10);

        // bounce: 2-cycle highs never complete the window
        set_ops(8'h3C, 5'h0A, 3'b101);
        for (int i = 0; i < 2; i++) begin
            btnC = 1'b1; repeat (2) tick();
            btnC = 1'b0; repeat (2) tick();
        end
        btnC = 1'b1;
        expect_pulse(cyc + LAT);
        repeat (10) tick();
        release_and_check();

        // long hold; operands change after capture
        set_ops(8'h5A, 5'h1F, 3'b111);
        btnC = 1'b1;
        expect_pulse(cyc + LAT);
        repeat (10) tick();
        sw = 8'hFF; sw2 = 5'h00; sel = 3'b000;
        repeat (40) tick();
        check("hold_a", a_q, 8'h5A);
        check("hold_b", b_q, 5'h1F);
        check("hold_sel", sel_q, 3'b111);
        release_and_check();
        repeat (10) tick();
        check("after_release_a", a_q, 8'h5A);

        // release glitch while held
        set_ops(8'h81, 5'h04, 3'b001);
        btnC = 1'b1;
        expect_pulse(cyc + LAT);
        repeat (10) tick();
        btnC = 1'b0; repeat (2) tick();
        btnC = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("glitch_btn_db", btn_db, 1'b1);
        end
        #1;
        release_and_check();

        // reset mid-debounce
        set_ops(8'hC3, 5'h15, 3'b110);
        btnC = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("async_reset", {a_q, 3'b0, b_q, 5'b0, sel_q, btn_db, op_valid, cap_cnt}, 32'd0);
        exp_cnt = 8'd0;
        repeat (3) tick();
        rst = 1'b0;
        expect_pulse(cyc + LAT);
        repeat (10) tick();
        release_and_check();

        // wrap-around from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 8'd0;
        tick();
        n0 = n_pulses;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            sw = iv; sw2 = iv[4:0] ^ 5'h15; sel = iv[2:0];
            repeat (3) tick();
            btnC = 1'b1;
            expect_pulse(cyc + LAT);
            repeat (8) tick();
            release_and_check();
        end
        check("wrap_cnt", cap_cnt, 8'd0);
        check("wrap_pulses", n_pulses - n0, 256);

        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation bound expired");
        $fatal(1);
    end

endmodule
